// File: rtl/tpu_cmd_sched.sv
// tpu_cmd_sched: queues GEMM commands and launches them one at a time on the TPU.
// Optional watchdog abort is compiled in when TPU_SCHED_WATCHDOG_EN is defined.
//
// state     | meaning
// IDLE      | waiting for a queued command; pops the FIFO head when present
// LAUNCH    | one-cycle tpu_in_valid strobe; cycle counter set to 1
// WAIT_BUSY | strobe issued, waiting for tpu_busy to rise
// RUN       | TPU busy, counting until busy falls
// REPORT    | completion record presented until done_ready
module tpu_cmd_sched #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 24,
    parameter int TMO_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_k,
    input  logic [7:0]               cmd_m,
    input  logic [7:0]               cmd_n,
    input  logic [3:0]               cmd_tag,
    output logic                     tpu_in_valid,
    output logic [7:0]               tpu_k,
    output logic [7:0]               tpu_m,
    output logic [7:0]               tpu_n,
    input  logic                     tpu_busy,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic [3:0]               done_tag,
    output logic [CNT_W-1:0]         done_cycles,
    output logic                     done_err,
    output logic [$clog2(DEPTH):0]   q_level,
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 28;
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_RUN,
        S_REPORT
    } state_t;

    state_t state, state_nxt;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full_q;
    logic             push, pop;
    logic [AW:0]      lvl_nxt;
    logic [7:0]       head_k, head_m, head_n;
    logic [3:0]       head_tag;
    logic             head_zero;

    logic [3:0]       job_tag;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr, cnt_inc;
    logic             rpt_ld;
    logic [3:0]       rpt_tag;
    logic [CNT_W-1:0] rpt_cycles;

    assign cmd_ready = !full_q;
    assign push      = cmd_valid && !full_q;
    assign {head_tag, head_n, head_m, head_k} = mem[rd_ptr];
    assign head_zero = (head_k == 8'd0) || (head_m == 8'd0) || (head_n == 8'd0);

    always_comb begin
        lvl_nxt = q_level;
        if (push && !pop) begin
            lvl_nxt = q_level + 1'b1;
        end else if (pop && !push) begin
            lvl_nxt = q_level - 1'b1;
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_tag, cmd_n, cmd_m, cmd_k};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_level <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            q_level <= lvl_nxt;
            full_q  <= (lvl_nxt == LVL_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef TPU_SCHED_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(16);
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TMO_CYC);
    logic rpt_err;
`endif

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        rpt_ld     = 1'b0;
        rpt_tag    = job_tag;
        rpt_cycles = cnt;
`ifdef TPU_SCHED_WATCHDOG_EN
        rpt_err    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (q_level != '0) begin
                    pop = 1'b1;
                    if (head_zero) begin
                        state_nxt  = S_REPORT;
                        rpt_ld     = 1'b1;
                        rpt_tag    = head_tag;
                        rpt_cycles = '0;
                    end else begin
                        state_nxt = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_clr   = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                cnt_inc = 1'b1;
                if (tpu_busy) begin
                    state_nxt = S_RUN;
                end
`ifdef TPU_SCHED_WATCHDOG_EN
                if ((cnt >= WAIT_LIM) || (cnt >= TMO_LIM)) begin
                    state_nxt = S_REPORT;
                    rpt_ld    = 1'b1;
                    rpt_err   = 1'b1;
                end
`endif
            end
            S_RUN: begin
                cnt_inc = 1'b1;
                if (!tpu_busy) begin
                    state_nxt = S_REPORT;
                    rpt_ld    = 1'b1;
                end
`ifdef TPU_SCHED_WATCHDOG_EN
                if (cnt >= TMO_LIM) begin
                    state_nxt = S_REPORT;
                    rpt_ld    = 1'b1;
                    rpt_err   = 1'b1;
                end
`endif
            end
            S_REPORT: begin
                if (done_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The counter value in a cycle equals cycles elapsed since the strobe,
    // so capturing it on exit gives strobe-to-busy-fall directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpu_k       <= '0;
            tpu_m       <= '0;
            tpu_n       <= '0;
            job_tag     <= '0;
            cnt         <= '0;
            done_tag    <= '0;
            done_cycles <= '0;
        end else begin
            if (pop) begin
                tpu_k   <= head_k;
                tpu_m   <= head_m;
                tpu_n   <= head_n;
                job_tag <= head_tag;
            end
            if (cnt_clr) begin
                cnt <= CNT_W'(1);
            end else if (cnt_inc && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
            if (rpt_ld) begin
                done_tag    <= rpt_tag;
                done_cycles <= rpt_cycles;
            end
        end
    end

`ifdef TPU_SCHED_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_err <= 1'b0;
        end else if (rpt_ld) begin
            done_err <= rpt_err;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYC;
    assign done_err   = 1'b0;
`endif

    assign tpu_in_valid = (state == S_LAUNCH);
    assign done_valid   = (state == S_REPORT);
    assign idle         = (state == S_IDLE) && (q_level == '0);

endmodule

// File: tb/tb_tpu_cmd_sched.sv
// Scoreboard bench for tpu_cmd_sched: a TPU busy model, in-order job queue and
// per-cycle completion checks; directed scenarios followed by random traffic.
module tb_tpu_cmd_sched;
    localparam int DEPTH = 4;
    localparam int CNT_W = 24;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_k, cmd_m, cmd_n;
    logic [3:0]       cmd_tag;
    logic             tpu_in_valid;
    logic [7:0]       tpu_k, tpu_m, tpu_n;
    logic             tpu_busy = 1'b0;
    logic             done_valid;
    logic             done_ready = 1'b0;
    logic [3:0]       done_tag;
    logic [CNT_W-1:0] done_cycles;
    logic             done_err;
    logic [AW:0]      q_level;
    logic             idle;

    tpu_cmd_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TMO_CYC(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_k(cmd_k), .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_tag(cmd_tag),
        .tpu_in_valid(tpu_in_valid), .tpu_k(tpu_k), .tpu_m(tpu_m), .tpu_n(tpu_n),
        .tpu_busy(tpu_busy),
        .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag),
        .done_cycles(done_cycles), .done_err(done_err),
        .q_level(q_level), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] k;
        logic [7:0] m;
        logic [7:0] n;
        logic [3:0] tag;
    } job_t;

    job_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0, strobe_cnt = 0, strobe_cyc = 0, push_cyc = 0;
    int   cfg_d = 0, cfg_b = 0, dr_mode = 0;
    bit   never_busy = 1'b0;
    int   start_cd = 0, run_cd = 0, cur_b = 0, tpu_d = 0;
    bit   cur_strobed = 1'b0;
    int   cur_exp_cyc = 0;
    bit   cur_exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_zero(input job_t j);
        return (j.k == 8'd0) || (j.m == 8'd0) || (j.n == 8'd0);
    endfunction

    // Monitor, TPU busy model and completion consumer; all act mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            cur_strobed = 1'b0;
            start_cd    = 0;
            run_cd      = 0;
            tpu_busy    = 1'b0;
            done_ready  = 1'b0;
        end else begin
            if (start_cd > 0) begin
                start_cd--;
                if (start_cd == 0) begin
                    tpu_busy = 1'b1;
                    run_cd   = cur_b;
                end
            end else if (run_cd > 0) begin
                run_cd--;
                if (run_cd == 0) tpu_busy = 1'b0;
            end
            case (dr_mode)
                0:       done_ready = 1'b1;
                1:       done_ready = ($urandom_range(0, 3) != 0);
                default: done_ready = 1'b0;
            endcase

            if (tpu_in_valid) begin
                strobe_cnt++;
                strobe_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_unexpected: pending jobs 0 required >=1 (cycle %0d)", cyc);
                end else begin
                    chk("strobe_once", 32'(cur_strobed), 32'd0);
                    chk("strobe_nonzero_job", 32'(is_zero(exp_q[0])), 32'd0);
                    chk("strobe_dims", 32'({tpu_k, tpu_m, tpu_n}),
                        32'({exp_q[0].k, exp_q[0].m, exp_q[0].n}));
                    cur_strobed = 1'b1;
                    if (never_busy) begin
                        cur_exp_cyc = 16;
                        cur_exp_err = 1'b1;
                    end else begin
                        tpu_d       = (cfg_d != 0) ? cfg_d : int'($urandom_range(1, 3));
                        cur_b       = (cfg_b != 0) ? cfg_b : int'($urandom_range(1, 12));
                        start_cd    = tpu_d;
                        cur_exp_cyc = tpu_d + cur_b;
                        cur_exp_err = 1'b0;
                    end
                end
            end

            if (tpu_busy && exp_q.size() > 0) begin
                chk("dims_stable_busy", 32'({tpu_k, tpu_m, tpu_n}),
                    32'({exp_q[0].k, exp_q[0].m, exp_q[0].n}));
            end

            if (done_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: pending jobs 0 required >=1 (cycle %0d)", cyc);
                end else begin
                    chk("done_tag", 32'(done_tag), 32'(exp_q[0].tag));
                    if (is_zero(exp_q[0])) begin
                        chk("zero_done_cycles", 32'(done_cycles), 32'd0);
                        chk("zero_done_err", 32'(done_err), 32'd0);
                    end else begin
                        chk("done_after_strobe", 32'(cur_strobed), 32'd1);
                        chk("done_cycles", 32'(done_cycles), 32'(cur_exp_cyc));
                        chk("done_err", 32'(done_err), 32'(cur_exp_err));
                    end
                    if (done_ready) begin
                        void'(exp_q.pop_front());
                        cur_strobed = 1'b0;
                    end
                end
            end

            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(job_t'({cmd_k, cmd_m, cmd_n, cmd_tag}));
                push_cyc = cyc;
            end
        end
    end

    // All main-thread activity sits at posedge+1.
    task automatic push(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n,
                        input logic [3:0] tag);
        int t = 0;
        cmd_k     = k;
        cmd_m     = m;
        cmd_n     = n;
        cmd_tag   = tag;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 600) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: tag %0d accepted 0 required 1", tag);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(posedge clk);
            #1;
            if (idle && exp_q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: idle %0d pending %0d required idle 1 pending 0",
                     idle, exp_q.size());
        end
    endtask

    task automatic wait_strobe(input int prev, input int budget);
        bit ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(posedge clk);
            #1;
            if (strobe_cnt != prev) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: strobes %0d required %0d", strobe_cnt, prev + 1);
        end
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(posedge clk);
            #1;
            if (done_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done_valid 0 required 1");
        end
    endtask

    initial begin
        int s0, s1, z;
        logic [7:0] rk, rm, rn;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_k     = '0;
        cmd_m     = '0;
        cmd_n     = '0;
        cmd_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_tpu_in_valid", 32'(tpu_in_valid), 32'd0);
        chk("rst_tpu_dims", 32'({tpu_k, tpu_m, tpu_n}), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_tag", 32'(done_tag), 32'd0);
        chk("rst_done_cycles", 32'(done_cycles), 32'd0);
        chk("rst_done_err", 32'(done_err), 32'd0);
        chk("rst_q_level", 32'(q_level), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single job: busy rises 1 cycle after strobe, held 20 cycles
        cfg_d = 1;
        cfg_b = 20;
        s0 = strobe_cnt;
        push(8'd4, 8'd4, 8'd4, 4'd3);
        wait_idle(200);
        chk("single_strobe_count", 32'(strobe_cnt - s0), 32'd1);
        chk("launch_latency", 32'(strobe_cyc - push_cyc), 32'd2);

        // Zero dimension: no strobe, immediate report
        s0 = strobe_cnt;
        push(8'd9, 8'd0, 8'd6, 4'd7);
        wait_idle(100);
        chk("zero_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        chk("zero_tpu_k_loaded", 32'(tpu_k), 32'd9);
        chk("zero_tpu_m_loaded", 32'(tpu_m), 32'd0);

        // Backpressure: record held, second job must not launch
        cfg_d = 2;
        cfg_b = 5;
        dr_mode = 2;
        s0 = strobe_cnt;
        push(8'd3, 8'd5, 8'd7, 4'd1);
        push(8'd2, 8'd2, 8'd2, 4'd2);
        wait_done(100);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("bp_strobe_count", 32'(strobe_cnt - s0), 32'd1);
        chk("bp_done_held", 32'(done_valid), 32'd1);
        chk("bp_q_level", 32'(q_level), 32'd1);
        dr_mode = 0;
        wait_idle(200);
        chk("bp_total_strobes", 32'(strobe_cnt - s0), 32'd2);

        // Queue fill while TPU busy, then wrap
        cfg_d = 1;
        cfg_b = 80;
        s0 = strobe_cnt;
        push(8'd1, 8'd1, 8'd1, 4'd0);
        wait_strobe(s0, 50);
        for (int i = 1; i <= DEPTH; i++) push(8'(i), 8'd2, 8'd3, 4'(i));
        chk("fill_q_level", 32'(q_level), 32'(DEPTH));
        chk("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        push(8'd8, 8'd8, 8'd8, 4'(DEPTH + 1));
        wait_idle(3000);

        // Reset in RUN with two jobs queued
        cfg_b = 100;
        s0 = strobe_cnt;
        push(8'd2, 8'd3, 8'd4, 4'd10);
        wait_strobe(s0, 50);
        push(8'd5, 8'd5, 8'd5, 4'd11);
        push(8'd6, 8'd6, 8'd6, 4'd12);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_idle", 32'(idle), 32'd1);
        chk("midrst_q_level", 32'(q_level), 32'd0);
        chk("midrst_done_valid", 32'(done_valid), 32'd0);
        chk("midrst_tpu_in_valid", 32'(tpu_in_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        s1 = strobe_cnt;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        chk("postrst_no_strobe", 32'(strobe_cnt - s1), 32'd0);
        chk("postrst_idle", 32'(idle), 32'd1);

        // Random traffic with random backpressure and TPU timing
        cfg_d = 0;
        cfg_b = 0;
        dr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            z  = int'($urandom_range(0, 9));
            rk = (z == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rm = (z == 1) ? 8'd0 : 8'($urandom_range(1, 255));
            rn = (z == 2) ? 8'd0 : 8'($urandom_range(1, 255));
            push(rk, rm, rn, 4'(i));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle(5000);

`ifdef TPU_SCHED_WATCHDOG_EN
        dr_mode = 0;
        never_busy = 1'b1;
        s0 = strobe_cnt;
        push(8'd4, 8'd4, 8'd4, 4'd9);
        wait_idle(200);
        chk("wd_strobe_count", 32'(strobe_cnt - s0), 32'd1);
        never_busy = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time exceeded, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/tpu_cmd_sched.md
# tpu_cmd_sched

Command scheduler in front of the TPU matrix-multiply engine. Queues GEMM commands (K, M, N plus a tag) from the CFU front end and launches them on the TPU one at a time. It pulses the TPU start strobe, tracks the TPU busy flag to detect completion, and returns a tagged completion record with a cycle count. It is the only driver of the TPU's in_valid/K/M/N inputs.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- CNT_W, 24, width of the per-job cycle counter
- TMO_CYC, 4096, watchdog limit in cycles (used only with the watchdog macro)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_k, cmd_m, cmd_n  in  8 each  GEMM dimensions
- cmd_tag  in  4  opaque job ID, echoed on completion
- tpu_in_valid  out  1  one-cycle TPU start strobe
- tpu_k, tpu_m, tpu_n  out  8 each  dimensions presented to the TPU
- tpu_busy  in  1  TPU busy flag
- done_valid  out  1  completion record valid
- done_ready  in  1  completion consumer ready
- done_tag  out  4  tag of the finished job
- done_cycles  out  CNT_W  cycles from strobe to busy falling; saturating
- done_err  out  1  job aborted by the watchdog
- q_level  out  log2(DEPTH)+1  FIFO occupancy
- idle  out  1  FIFO empty and FSM in IDLE

## Operation
- Handshakes:
  - A command is pushed when cmd_valid && cmd_ready.
  - A completion is retired when done_valid && done_ready.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, RUN, REPORT.
- IDLE:
  - FIFO non-empty → pop the head into job registers, then go to LAUNCH.
  - If the popped job has K, M or N equal to 0 → go directly to REPORT with done_cycles=0 and done_err=0. No strobe is issued.
- LAUNCH: tpu_in_valid=1 for exactly this one cycle, then go to WAIT_BUSY. The cycle counter clears to 1.
- WAIT_BUSY: stay until tpu_busy=1, then go to RUN.
- RUN: stay while tpu_busy=1. On tpu_busy=0 → go to REPORT.
- Cycle counter:
  - Increments every cycle in WAIT_BUSY and RUN.
  - Saturates at 2^CNT_W−1.
- REPORT:
  - done_valid=1; the tag, cycles and err outputs are held stable.
  - On done_ready → go to IDLE.
  - A new pop may occur in the IDLE cycle that immediately follows.
- tpu_k/m/n are registered at pop time and held stable until the next pop. They never change while tpu_busy=1.
- FIFO:
  - Push at full is impossible because cmd_ready=0 when full.
  - Push and pop in the same cycle are allowed when not full; q_level stays unchanged.
  - Pointers wrap modulo DEPTH.
  - Commands launch in arrival order.

## Timing
- Reset values:
  - cmd_ready=1, tpu_in_valid=0, tpu_k/m/n=0.
  - done_valid=0, done_tag=0, done_cycles=0, done_err=0.
  - q_level=0, idle=1.
  - FSM in IDLE; FIFO empty.
- Reset mid-job: all state clears at once and any queued commands are lost. tpu_in_valid deasserts asynchronously.
- Latency from a push into an empty, idle scheduler to tpu_in_valid: 2 cycles (push, then pop in IDLE, then LAUNCH).
- cmd_ready updates in the cycle after a push or pop; it is a registered full flag.
- done_valid is registered and rises the cycle after busy is seen low in RUN.
- tpu_busy is sampled synchronously only.
- A tpu_busy glitch while in IDLE or REPORT is ignored.

## Configuration
- TPU_SCHED_WATCHDOG_EN defined:
  - If WAIT_BUSY lasts 16 cycles, or WAIT_BUSY+RUN reaches TMO_CYC cycles, the FSM goes to REPORT with done_err=1.
  - done_cycles holds the count at the moment of the abort.
- TPU_SCHED_WATCHDOG_EN undefined:
  - No timeout; the FSM waits indefinitely.
  - done_err is tied to 0 and TMO_CYC is unused.

## Test plan
- Single job: push K=4, M=4, N=4, tag=3; the TPU model holds busy for 20 cycles.
  - Expect exactly one tpu_in_valid pulse 2 cycles after the push, with tpu_k/m/n=4.
  - Expect done_valid with done_tag=3 and done_cycles equal to the model's strobe-to-busy-fall interval.
- Queue fill: push DEPTH+1 commands back to back while the TPU is busy.
  - Expect cmd_ready=0 after DEPTH entries and q_level=DEPTH.
  - Expect tags to complete in FIFO order after pointer wrap.
- Zero dimension: push M=0, tag=7.
  - Expect no tpu_in_valid.
  - Expect done_valid with tag=7, cycles=0, err=0.
- Backpressure: hold done_ready=0 for 10 cycles during REPORT.
  - Expect done fields stable throughout.
  - Expect no second strobe until the record is retired.
- Reset mid-RUN with 2 jobs queued.
  - Expect idle=1, q_level=0, done_valid=0 immediately.
  - Expect no further strobes.
- Watchdog (macro defined): the TPU model never raises busy.
  - Expect done_err=1 and done_cycles=16.
